// File: rtl/seq_add16.sv
// Multi-cycle adder: one SLICE-bit ripple slice is reused for WIDTH/SLICE cycles,
// with a registered carry between slices and a start/busy/done handshake.
module seq_add16 #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] aReg_q, aReg_d;
  logic [WIDTH-1:0] bReg_q, bReg_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] aSlice, bSlice;
  logic [SLICE:0]   sliceSum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      aReg_q  <= '0;
      bReg_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      aReg_q  <= aReg_d;
      bReg_q  <= bReg_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    aSlice   = aReg_q[idx_q*SLICE +: SLICE];
    bSlice   = bReg_q[idx_q*SLICE +: SLICE];
    sliceSum = {1'b0, aSlice} + {1'b0, bSlice} + {{SLICE{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    aReg_d  = aReg_q;
    bReg_d  = bReg_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          aReg_d  = a;
          bReg_d  = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[idx_q*SLICE +: SLICE] = sliceSum[SLICE-1:0];
        carry_d = sliceSum[SLICE];
        idx_d   = idx_q + IDXW'(1);
        // Last slice: publish the completed accumulator, including the slice just computed.
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          sum_d   = acc_d;
          cout_d  = sliceSum[SLICE];
          ovf_d   = (aReg_q[WIDTH-1] == bReg_q[WIDTH-1]) &&
                    (acc_d[WIDTH-1] != aReg_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_add16.sv
// Directed-vector bench for seq_add16: reset, arithmetic corners, handshake timing
// and mid-operation abort, each checked against hand-computed values.
module tb_seq_add16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checkCount;
  int errorCount;

  seq_add16 #(.WIDTH(16), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_sum"},  {16'd0, sum},  32'd0);
    checkOutput({tag, "_cout"}, {31'd0, cout}, 32'd0);
    checkOutput({tag, "_ovf"},  {31'd0, ovf},  32'd0);
  endtask

  // Full operation with cycle-accurate handshake checks; operands are scrambled
  // right after the accept edge so only captured values may reach the result.
  task automatic applyStimulus(input string tag, input logic [15:0] opA,
                               input logic [15:0] opB, input logic opCin,
                               input logic [15:0] expSum, input logic expCout,
                               input logic expOvf);
    @(negedge clk);
    a = opA; b = opB; cin = opCin; start = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_busyE"}, {31'd0, busy}, 32'd1);
    checkOutput({tag, "_doneE"}, {31'd0, done}, 32'd0);
    start = 1'b0;
    a = ~opA; b = ~opB; cin = ~opCin;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("%s_doneE%0d", tag, i), {31'd0, done}, 32'd0);
      checkOutput($sformatf("%s_busyE%0d", tag, i), {31'd0, busy}, 32'd1);
    end
    @(posedge clk); #1;
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_sum"},  {16'd0, sum},  {16'd0, expSum});
    checkOutput({tag, "_cout"}, {31'd0, cout}, {31'd0, expCout});
    checkOutput({tag, "_ovf"},  {31'd0, ovf},  {31'd0, expOvf});
    @(posedge clk); #1;
    checkOutput({tag, "_doneE5"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_busyE5"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_sumHold"}, {16'd0, sum}, {16'd0, expSum});
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    #2;
    checkIdleZero("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("basic", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle must clear the held result immediately.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkIdleZero("rstAsync");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("cinMix", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    applyStimulus("ovfPos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    applyStimulus("ovfNeg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Handshake: start held high across RUN/DONE is only accepted once back in IDLE.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_busyE", {31'd0, busy}, 32'd1);
    a = 16'hAAAA; b = 16'h5555;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hs_doneE3", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    checkOutput("hs_done1", {31'd0, done}, 32'd1);
    checkOutput("hs_sum1",  {16'd0, sum},  32'h0000_0100);
    checkOutput("hs_cout1", {31'd0, cout}, 32'd0);
    @(posedge clk); #1;
    checkOutput("hs_idleBusy", {31'd0, busy}, 32'd0);
    checkOutput("hs_idleDone", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    checkOutput("hs_accept2", {31'd0, busy}, 32'd1);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hs_sumHold", {16'd0, sum}, 32'h0000_0100);
    checkOutput("hs_done2E3", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    checkOutput("hs_done2", {31'd0, done}, 32'd1);
    checkOutput("hs_sum2",  {16'd0, sum},  32'h0000_FFFF);
    checkOutput("hs_cout2", {31'd0, cout}, 32'd0);
    checkOutput("hs_ovf2",  {31'd0, ovf},  32'd0);
    @(posedge clk); #1;
    checkOutput("hs_end", {31'd0, busy}, 32'd0);

    // Abort: reset after slice 1 completes; no done pulse may follow.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("ab_busyE", {31'd0, busy}, 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkIdleZero("abort");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("ab_noDone%0d", i), {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("postAbort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
